// File: rtl/hyperram_reset_seq.sv
// HyperRAM power-up/recovery reset sequencer: lock filter, RESET# pulse, tVCS wait, ordered stage releases.
// Optional lock-loss event counter enabled by defining HYPERRAM_RESET_SEQ_LOSS_CNT_EN.
module hyperram_reset_seq #(
    parameter int N_STAGES      = 4,
    parameter int LOCK_FILT_CYC = 8,
    parameter int RAM_RST_CYC   = 40,
    parameter int VCS_CYC       = 15000,
    parameter int STAGE_GAP_CYC = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_locked,
    input  logic                sw_rst_req,
    output logic                ram_rst_l,
    output logic [N_STAGES-1:0] stage_rst,
    output logic                seq_done,
    output logic [2:0]          seq_state,
    output logic [7:0]          loss_cnt
);

    localparam int IW = $clog2(N_STAGES) + 1;
    localparam logic [N_STAGES-1:0] FIRST_MASK = N_STAGES'(1);
    localparam logic [N_STAGES-1:0] ALL_ONES   = '1;

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_RAM_RST  = 3'd1,
        S_VCS_WAIT = 3'd2,
        S_STAGE    = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [23:0]         cnt_reg, cnt_next;
    logic [7:0]          filt_reg, filt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [N_STAGES-1:0] stage_rst_reg, stage_rst_next;
    logic                ram_rst_l_reg, ram_rst_l_next;
    logic                seq_done_reg, seq_done_next;
    logic [N_STAGES-1:0] release_mask;
    logic                in_hold;
    logic                abort;
    logic                lock_valid;
    logic                cnt_zero;

    // Unused encodings 5..7 are treated as HOLD so the block always recovers.
    assign in_hold    = !(state_reg inside {S_RAM_RST, S_VCS_WAIT, S_STAGE, S_RUN});
    assign abort      = !pll_locked || sw_rst_req;
    assign lock_valid = pll_locked && !sw_rst_req;
    assign cnt_zero   = (cnt_reg == 24'd0);

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_release
            assign release_mask[gi] = (idx_reg == IW'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        filt_next      = filt_reg;
        idx_next       = idx_reg;
        stage_rst_next = stage_rst_reg;
        ram_rst_l_next = ram_rst_l_reg;
        seq_done_next  = seq_done_reg;

        if (in_hold) begin
            state_next     = S_HOLD;
            stage_rst_next = ALL_ONES;
            ram_rst_l_next = 1'b0;
            seq_done_next  = 1'b0;
            idx_next       = '0;
            if (lock_valid) begin
                if (filt_reg == 8'(LOCK_FILT_CYC - 1)) begin
                    state_next = S_RAM_RST;
                    cnt_next   = 24'(RAM_RST_CYC - 1);
                    filt_next  = 8'd0;
                end else begin
                    filt_next = filt_reg + 8'd1;
                end
            end else begin
                filt_next = 8'd0;
            end
        end else if (abort) begin
            // Abort takes precedence over any release due on this edge.
            state_next     = S_HOLD;
            stage_rst_next = ALL_ONES;
            ram_rst_l_next = 1'b0;
            seq_done_next  = 1'b0;
            filt_next      = 8'd0;
            cnt_next       = 24'd0;
            idx_next       = '0;
        end else begin
            case (state_reg)
                S_RAM_RST: begin
                    if (cnt_zero) begin
                        state_next     = S_VCS_WAIT;
                        ram_rst_l_next = 1'b1;
                        cnt_next       = 24'(VCS_CYC - 1);
                    end else begin
                        cnt_next = cnt_reg - 24'd1;
                    end
                end
                S_VCS_WAIT: begin
                    if (cnt_zero) begin
                        stage_rst_next = stage_rst_reg & ~FIRST_MASK;
                        idx_next       = IW'(1);
                        if (N_STAGES == 1) begin
                            state_next    = S_RUN;
                            seq_done_next = 1'b1;
                        end else begin
                            state_next = S_STAGE;
                            cnt_next   = 24'(STAGE_GAP_CYC - 1);
                        end
                    end else begin
                        cnt_next = cnt_reg - 24'd1;
                    end
                end
                S_STAGE: begin
                    if (cnt_zero) begin
                        stage_rst_next = stage_rst_reg & ~release_mask;
                        idx_next       = idx_reg + IW'(1);
                        if (idx_reg == IW'(N_STAGES - 1)) begin
                            state_next    = S_RUN;
                            seq_done_next = 1'b1;
                        end else begin
                            cnt_next = 24'(STAGE_GAP_CYC - 1);
                        end
                    end else begin
                        cnt_next = cnt_reg - 24'd1;
                    end
                end
                default: begin
                    // S_RUN: idle, outputs held
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_HOLD;
            cnt_reg       <= 24'd0;
            filt_reg      <= 8'd0;
            idx_reg       <= '0;
            stage_rst_reg <= ALL_ONES;
            ram_rst_l_reg <= 1'b0;
            seq_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            filt_reg      <= filt_next;
            idx_reg       <= idx_next;
            stage_rst_reg <= stage_rst_next;
            ram_rst_l_reg <= ram_rst_l_next;
            seq_done_reg  <= seq_done_next;
        end
    end

`ifdef HYPERRAM_RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_reg;

    // Only lock loss counts; a simultaneous software request still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt_reg <= 8'd0;
        end else if (!in_hold && !pll_locked && (loss_cnt_reg != 8'hFF)) begin
            loss_cnt_reg <= loss_cnt_reg + 8'd1;
        end
    end

    assign loss_cnt = loss_cnt_reg;
`else
    assign loss_cnt = 8'd0;
`endif

    assign ram_rst_l = ram_rst_l_reg;
    assign stage_rst = stage_rst_reg;
    assign seq_done  = seq_done_reg;
    assign seq_state = state_reg;

endmodule

// File: tb/tb_hyperram_reset_seq.sv
// Directed bench for hyperram_reset_seq with N_STAGES=3, LOCK_FILT_CYC=3, RAM_RST_CYC=4, VCS_CYC=10, STAGE_GAP_CYC=2.
module tb_hyperram_reset_seq;

`ifdef HYPERRAM_RESET_SEQ_LOSS_CNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       ram_rst_l;
    logic [2:0] stage_rst;
    logic       seq_done;
    logic [2:0] seq_state;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    hyperram_reset_seq #(
        .N_STAGES(3),
        .LOCK_FILT_CYC(3),
        .RAM_RST_CYC(4),
        .VCS_CYC(10),
        .STAGE_GAP_CYC(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .ram_rst_l(ram_rst_l),
        .stage_rst(stage_rst),
        .seq_done(seq_done),
        .seq_state(seq_state),
        .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_state", 32'(seq_state), 32'd0);
        check("rst_stage", 32'(stage_rst), 32'h7);
        check("rst_ram", 32'(ram_rst_l), 32'd0);
        check("rst_done", 32'(seq_done), 32'd0);
        check("rst_loss", 32'(loss_cnt), 32'd0);

        // Nominal sequence: edge k is the k-th step after pll_locked rises
        pll_locked = 1'b1;
        steps(2);                                     // edges 0,1
        check("nom_e1_state", 32'(seq_state), 32'd0);
        step();                                       // edge 2
        check("nom_e2_state", 32'(seq_state), 32'd1);
        steps(3);                                     // edge 5
        check("nom_e5_ram", 32'(ram_rst_l), 32'd0);
        step();                                       // edge 6
        check("nom_e6_ram", 32'(ram_rst_l), 32'd1);
        check("nom_e6_state", 32'(seq_state), 32'd2);
        steps(9);                                     // edge 15
        check("nom_e15_stage", 32'(stage_rst), 32'h7);
        step();                                       // edge 16
        check("nom_e16_stage", 32'(stage_rst), 32'h6);
        check("nom_e16_state", 32'(seq_state), 32'd3);
        step();                                       // edge 17
        check("nom_e17_stage", 32'(stage_rst), 32'h6);
        step();                                       // edge 18
        check("nom_e18_stage", 32'(stage_rst), 32'h4);
        step();                                       // edge 19
        check("nom_e19_done", 32'(seq_done), 32'd0);
        step();                                       // edge 20
        check("nom_e20_stage", 32'(stage_rst), 32'h0);
        check("nom_e20_done", 32'(seq_done), 32'd1);
        check("nom_e20_state", 32'(seq_state), 32'd4);
        steps(5);
        check("run_hold_stage", 32'(stage_rst), 32'h0);
        check("run_hold_done", 32'(seq_done), 32'd1);

        // Lock glitch in HOLD: 1,1,0,1,1,1
        do_reset();
        pll_locked = 1'b1; step(); step();            // edges 0,1
        pll_locked = 1'b0; step();                    // edge 2
        check("glitch_e2_state", 32'(seq_state), 32'd0);
        pll_locked = 1'b1; step(); step();            // edges 3,4
        check("glitch_e4_state", 32'(seq_state), 32'd0);
        step();                                       // edge 5
        check("glitch_e5_state", 32'(seq_state), 32'd1);

        // Lock loss mid-sequence at edge 17, relock from edge 18
        do_reset();
        pll_locked = 1'b1;
        steps(17);                                    // edges 0..16
        check("loss_e16_stage", 32'(stage_rst), 32'h6);
        pll_locked = 1'b0; step();                    // edge 17
        check("loss_e17_stage", 32'(stage_rst), 32'h7);
        check("loss_e17_ram", 32'(ram_rst_l), 32'd0);
        check("loss_e17_state", 32'(seq_state), 32'd0);
        check("loss_e17_done", 32'(seq_done), 32'd0);
        check("loss_e17_cnt", 32'(loss_cnt), 32'(LOSS_EN));
        pll_locked = 1'b1;
        steps(3);                                     // edges 18..20
        check("relock_e20_state", 32'(seq_state), 32'd1);
        steps(3);                                     // edge 23
        check("relock_e23_ram", 32'(ram_rst_l), 32'd0);
        step();                                       // edge 24
        check("relock_e24_ram", 32'(ram_rst_l), 32'd1);

        // sw_rst_req on the same edge as the final stage release
        do_reset();
        pll_locked = 1'b1;
        steps(20);                                    // edges 0..19
        check("sw_e19_stage", 32'(stage_rst), 32'h4);
        sw_rst_req = 1'b1; step();                    // edge 20
        check("sw_e20_stage", 32'(stage_rst), 32'h7);
        check("sw_e20_done", 32'(seq_done), 32'd0);
        check("sw_e20_state", 32'(seq_state), 32'd0);
        check("sw_e20_loss", 32'(loss_cnt), 32'd0);
        // Held request keeps HOLD; sequencing restarts 3 valid samples after release
        steps(5);
        check("sw_held_state", 32'(seq_state), 32'd0);
        sw_rst_req = 1'b0;
        steps(2);
        check("sw_drop2_state", 32'(seq_state), 32'd0);
        step();
        check("sw_drop3_state", 32'(seq_state), 32'd1);

        // 300 lock-loss aborts: saturates at 255 when the counter is built
        do_reset();
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            steps(3);
            pll_locked = 1'b0;
            step();
        end
        check("sat_loss", 32'(loss_cnt), (LOSS_EN != 0) ? 32'd255 : 32'd0);

        // Reset priority from RUN with pll_locked still high
        pll_locked = 1'b1;
        steps(21);
        check("pre_rst_state", 32'(seq_state), 32'd4);
        reset = 1'b1; step();
        check("prio_state", 32'(seq_state), 32'd0);
        check("prio_stage", 32'(stage_rst), 32'h7);
        check("prio_ram", 32'(ram_rst_l), 32'd0);
        check("prio_done", 32'(seq_done), 32'd0);
        check("prio_loss", 32'(loss_cnt), 32'd0);
        step();
        check("prio_hold_state", 32'(seq_state), 32'd0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
